alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle core ALU.
- Adds XOR, SLTU, shifts, and sequential MUL, DIVU and REMU on top of ADD/SUB/AND/OR/SLT.
- Sits between decode/regfile read and writeback.
- Uses a valid/ready handshake on both sides so the pipeline can stall on multi-cycle ops.
- Result and zero flag are registered.

Parameters:
- XLEN, 32, operand/result width; legal values are powers of two ≥ 8.
- CTRLW, 4, width of the op-select field.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- ctrl  in  CTRLW  op select, sampled on accept.
- rs1  in  XLEN  operand A, sampled on accept.
- rs2  in  XLEN  operand B, sampled on accept.
- out_valid  out  1  rd/z hold a completed result.
- out_ready  in  1  consumer takes the result.
- rd  out  XLEN  result.
- z  out  1  high when rd == 0.
- busy  out  1  high when a multi-cycle op is in progress.

Behaviour:
- Reset is asynchronous, active-high and fixed; one clock (clk) only.
  - While rst is high: state=IDLE, out_valid=0, rd=0, z=0, busy=0, iteration counter=0.
  - in_ready=1 once rst is low.
  - Reset asserted mid-operation aborts the op; no result is produced.
- Op encoding (ctrl):
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 slt (signed); 0110 sltu.
  - 0111 sll; 1000 srl; 1001 sra.
  - 1010 mul (low XLEN bits of product, identical for signed/unsigned).
  - 1011 divu; 1100 remu.
  - 1101–1111 reserved: rd=0, z=1, latency 1.
- Shift amount = rs2[$clog2(XLEN)-1:0]; upper bits are ignored.
- slt/sltu return 1 or 0, zero-extended to XLEN.
- add/sub/mul wrap modulo 2^XLEN; no overflow flag.
- States are IDLE, BUSY, DONE.
- Accept occurs when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- IDLE:
  - Single-cycle op or reserved op: result registered on the accept edge, go to DONE. out_valid is high the cycle after accept (latency 1).
  - mul/divu/remu with a nonzero divisor (or any mul): operands latched, counter=0, go to BUSY.
- BUSY:
  - One iteration per cycle: shift-add for mul, restoring shift-subtract for divu/remu.
  - After XLEN iterations (counter reaches XLEN-1), go to DONE.
  - out_valid rises exactly XLEN+1 cycles after the accept edge.
  - busy=1 and in_ready=0 throughout; input ports are ignored.
- Divide by zero (rs2==0 for divu/remu): completes with latency 1.
  - divu returns all ones.
  - remu returns rs1.
- DONE:
  - out_valid=1; rd and z are held stable until out_ready.
  - On out_ready alone: go to IDLE, out_valid drops next cycle.
  - On out_ready with a same-cycle accept: the new op is processed as in IDLE, with no bubble between results.
- z is registered together with rd. It is never computed combinationally from the ports.
- No assumptions are made about ctrl/rs1/rs2 when in_valid is low.

Test Plan:
(All scenarios use XLEN=32.)
1. add rs1=20, rs2=30, out_ready=1 → rd=50, z=0, out_valid exactly 1 cycle after accept. sub 20,30 → rd=0xFFFFFFF6. sub 30,30 → rd=0, z=1.
2. slt 0xFFFFFFFF,1 → rd=1. sltu same operands → rd=0. sra 0x80000000 by rs2=0x24 (shamt 4) → 0xF8000000. srl same → 0x08000000. xor 0xFF00,0x0FF0 → 0xF0F0.
3. mul 1234,5678 → rd=7006652, out_valid 33 cycles after accept, busy=1 cycles 1–32, in_ready=0 meanwhile. mul 0x10000,0x10000 → rd=0, z=1.
4. divu 100,7 → 14. remu 100,7 → 2, both after 33 cycles. divu 100,0 → 0xFFFFFFFF after 1 cycle. remu 100,0 → 100 after 1 cycle.
5. Backpressure: add result with out_ready=0 for 5 cycles → rd/z/out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (and 5,5) in the same cycle → next cycle rd=5, out_valid=1 (back-to-back).
6. Assert rst 10 cycles into a mul → out_valid=0, busy=0 immediately. After release, in_ready=1 and add 1,2 → rd=3 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge. mul runs a shift-add loop and
// divu/remu run a restoring shift-subtract loop, one bit per cycle.
// rd and z are registered together and held until the consumer takes them.
module alu_mc #(
    parameter int XLEN  = 32,
    parameter int CTRLW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd,
    output logic             z,
    output logic             busy
);

    localparam int SHW = $clog2(XLEN);

    // Controller states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Op-select encodings
    localparam logic [CTRLW-1:0] OP_ADD  = CTRLW'(0);
    localparam logic [CTRLW-1:0] OP_SUB  = CTRLW'(1);
    localparam logic [CTRLW-1:0] OP_AND  = CTRLW'(2);
    localparam logic [CTRLW-1:0] OP_OR   = CTRLW'(3);
    localparam logic [CTRLW-1:0] OP_XOR  = CTRLW'(4);
    localparam logic [CTRLW-1:0] OP_SLT  = CTRLW'(5);
    localparam logic [CTRLW-1:0] OP_SLTU = CTRLW'(6);
    localparam logic [CTRLW-1:0] OP_SLL  = CTRLW'(7);
    localparam logic [CTRLW-1:0] OP_SRL  = CTRLW'(8);
    localparam logic [CTRLW-1:0] OP_SRA  = CTRLW'(9);
    localparam logic [CTRLW-1:0] OP_MUL  = CTRLW'(10);
    localparam logic [CTRLW-1:0] OP_DIVU = CTRLW'(11);
    localparam logic [CTRLW-1:0] OP_REMU = CTRLW'(12);

    // Which iterative operation is currently running
    localparam logic [1:0] MC_MUL = 2'd0;
    localparam logic [1:0] MC_DIV = 2'd1;
    localparam logic [1:0] MC_REM = 2'd2;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    logic [1:0]      state;
    logic [SHW-1:0]  cnt;
    logic [1:0]      mc_op;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    logic            accept;
    logic            is_long;
    logic            last_iter;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] quick_result;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] opa_next;
    logic [XLEN-1:0] opb_next;
    logic [XLEN-1:0] long_result;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);
    assign accept    = in_valid && in_ready;
    assign last_iter = (state == S_BUSY) && (cnt == CNT_LAST);
    assign shamt     = rs2[SHW-1:0];

    // Decode the request: single-cycle result, or flag that it needs the loop
    always_comb begin
        quick_result = '0;
        is_long      = 1'b0;
        case (ctrl)
            OP_ADD:  quick_result = rs1 + rs2;
            OP_SUB:  quick_result = rs1 - rs2;
            OP_AND:  quick_result = rs1 & rs2;
            OP_OR:   quick_result = rs1 | rs2;
            OP_XOR:  quick_result = rs1 ^ rs2;
            OP_SLT:  quick_result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU: quick_result = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            OP_SLL:  quick_result = rs1 << shamt;
            OP_SRL:  quick_result = rs1 >> shamt;
            OP_SRA:  quick_result = $signed(rs1) >>> shamt;
            OP_MUL:  is_long = 1'b1;
            OP_DIVU: begin
                if (rs2 == '0) begin
                    quick_result = '1;
                end else begin
                    is_long = 1'b1;
                end
            end
            OP_REMU: begin
                if (rs2 == '0) begin
                    quick_result = rs1;
                end else begin
                    is_long = 1'b1;
                end
            end
            default: quick_result = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        rem_shift = {acc, opa[XLEN-1]};
        trial     = rem_shift - {1'b0, opb};
        acc_next  = acc;
        opa_next  = opa;
        opb_next  = opb;
        if (mc_op == MC_MUL) begin
            if (opb[0]) begin
                acc_next = acc + opa;
            end
            opa_next = opa << 1;
            opb_next = opb >> 1;
        end else begin
            if (!trial[XLEN]) begin
                acc_next = trial[XLEN-1:0];
                opa_next = {opa[XLEN-2:0], 1'b1};
            end else begin
                acc_next = rem_shift[XLEN-1:0];
                opa_next = {opa[XLEN-2:0], 1'b0};
            end
        end
    end

    // Pick the finished value out of the loop registers on the last iteration
    always_comb begin
        long_result = acc_next;
        if (mc_op == MC_DIV) begin
            long_result = opa_next;
        end
    end

    // Controller: IDLE accepts, BUSY iterates, DONE holds until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= is_long ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        state <= is_long ? S_BUSY : S_DONE;
                    end else if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Iteration counter: cleared on a long-op accept, advances while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && is_long) begin
            cnt <= '0;
        end else if (state == S_BUSY) begin
            cnt <= cnt + SHW'(1);
        end
    end

    // Loop datapath: latch operands on accept, then step once per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            mc_op <= MC_MUL;
        end else if (accept && is_long) begin
            acc <= '0;
            opa <= rs1;
            opb <= rs2;
            if (ctrl == OP_MUL) begin
                mc_op <= MC_MUL;
            end else if (ctrl == OP_DIVU) begin
                mc_op <= MC_DIV;
            end else begin
                mc_op <= MC_REM;
            end
        end else if (state == S_BUSY) begin
            acc <= acc_next;
            opa <= opa_next;
            opb <= opb_next;
        end
    end

    // Result register: rd and z always written together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
            z  <= 1'b0;
        end else if (accept && !is_long) begin
            rd <= quick_result;
            z  <= (quick_result == '0);
        end else if (last_iter) begin
            rd <= long_result;
            z  <= (long_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against a
// transaction-level model (plain arithmetic plus a latency countdown).
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctrl = 4'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd;
    logic        z;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether a result is held, whether a long op is running
    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_rd    = 32'd0;
    logic [31:0] m_pend  = 32'd0;

    alu_mc #(.XLEN(32), .CTRLW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .rd(rd), .z(z), .busy(busy)
    );

    always #5 clk = ~clk;

    // Architectural result of one op, plus whether it takes the long path
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic long_op);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        long_op = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  r = $signed(a) >>> sh;
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                long_op = 1'b1;
            end
            4'd11: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin r = a / b; long_op = 1'b1; end
            end
            4'd12: begin
                if (b == 32'd0) r = a;
                else begin r = a % b; long_op = 1'b1; end
            end
            default: r = 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic ordy);
        in_valid  = v;
        ctrl      = op;
        rs1       = a;
        rs2       = b;
        out_ready = ordy;
    endtask

    // Model advance on each clock edge; reset clears it asynchronously
    always @(posedge clk or posedge rst) begin
        logic        rdy;
        logic        acc;
        logic [31:0] r;
        logic        lng;
        if (rst) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_left  = 0;
        end else begin
            rdy = !m_busy && (!m_valid || out_ready);
            acc = in_valid && rdy;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                    m_rd    = m_pend;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (acc) begin
                    model_op(ctrl, rs1, rs2, r, lng);
                    if (lng) begin
                        m_busy = 1'b1;
                        m_left = 32;
                        m_pend = r;
                    end else begin
                        m_valid = 1'b1;
                        m_rd    = r;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("in_ready", 32'(in_ready), 32'(!m_busy && (!m_valid || out_ready)));
            if (m_valid) begin
                checkOutput("rd", rd, m_rd);
                checkOutput("z", 32'(z), 32'(m_rd == 32'd0));
            end
        end
    end

    // Directed op with out_ready high: checks value, z, latency and busy span
    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        int busy_cycles;
        int ready_while_busy;
        @(negedge clk);
        applyStimulus(1'b1, op, a, b, 1'b1);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        lat = 1;
        busy_cycles = 0;
        ready_while_busy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cycles++;
            if (busy && in_ready) ready_while_busy++;
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, "_rd"}, rd, exp_rd);
        checkOutput({name, "_z"}, 32'(z), 32'(exp_rd == 32'd0));
        if (exp_lat > 1) begin
            checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
            checkOutput({name, "_ready_while_busy"}, 32'(ready_while_busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            3:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        lng;

        // Pin the model with hand-computed values
        model_op(4'd10, 32'd1234, 32'd5678, r, lng);
        checkOutput("model_mul", r, 32'd7006652);
        model_op(4'd11, 32'd100, 32'd7, r, lng);
        checkOutput("model_divu", r, 32'd14);
        model_op(4'd9, 32'h8000_0000, 32'h24, r, lng);
        checkOutput("model_sra", r, 32'hF800_0000);
        model_op(4'd12, 32'd100, 32'd0, r, lng);
        checkOutput("model_remu0", r, 32'd100);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rd", rd, 32'd0);
        checkOutput("reset_z", 32'(z), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("after_reset_in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops
        runOp("add", 4'd0, 32'd20, 32'd30, 32'd50, 1);
        runOp("sub_neg", 4'd1, 32'd20, 32'd30, 32'hFFFF_FFF6, 1);
        runOp("sub_zero", 4'd1, 32'd30, 32'd30, 32'd0, 1);
        runOp("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        runOp("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        runOp("sra", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        runOp("srl", 4'd8, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
        runOp("xor", 4'd4, 32'hFF00, 32'h0FF0, 32'hF0F0, 1);
        runOp("reserved", 4'd14, 32'd5, 32'd6, 32'd0, 1);

        // Multi-cycle ops and divide by zero
        runOp("mul", 4'd10, 32'd1234, 32'd5678, 32'd7006652, 33);
        runOp("mul_wrap", 4'd10, 32'h10000, 32'h10000, 32'd0, 33);
        runOp("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33);
        runOp("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33);
        runOp("divu_zero", 4'd11, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        runOp("remu_zero", 4'd12, 32'd100, 32'd0, 32'd100, 1);

        // Backpressure then a back-to-back accept in the releasing cycle
        @(negedge clk);
        applyStimulus(1'b1, 4'd0, 32'd7, 32'd8, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_rd", rd, 32'd15);
            checkOutput("bp_z", 32'(z), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        applyStimulus(1'b1, 4'd2, 32'd5, 32'd5, 1'b1);
        #1;
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("b2b_out_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_rd", rd, 32'd5);

        // Reset in the middle of a multiply
        @(negedge clk);
        applyStimulus(1'b1, 4'd10, 32'd1234, 32'd5678, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        repeat (9) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd", rd, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        runOp("post_abort_add", 4'd0, 32'd1, 32'd2, 32'd3, 1);

        // Randomized traffic checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          pickOperand(), pickOperand(), $urandom_range(0, 3) != 0);
        end

        // Drain whatever is in flight
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
